// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   Merges three reset sources (global reset port, asynchronous external
//   reset pin, software reset request) into one sequenced release of NCH
//   active-low reset outputs. Once every source has been idle for
//   HOLD_CYCLES cycles, channel 0 is released, then each further channel
//   follows STAGE_GAP cycles after the previous one, so subsystems leave
//   reset in index order. Any request during release or run drops every
//   channel at once and restarts the whole sequence.
//
// Parameters:
//   NCH          number of sequenced reset outputs (>=1)
//   SYNC_STAGES  synchroniser flops on ext_rst_n (>=2)
//   HOLD_CYCLES  idle cycles all outputs stay low before release starts (>=1)
//   STAGE_GAP    cycles between consecutive channel releases (>=1)
//
// Ports:
//   clk          in   1    single clock, all state on its rising edge
//   reset        in   1    synchronous, active-high global reset
//   ext_rst_n    in   1    asynchronous external reset, active low
//   soft_rst_req in   1    software reset request, level sensitive
//   resetn_out   out  NCH  sequenced resets, active low, registered
//   rst_done     out  1    high when every channel is released (RUN)
//   rst_cause    out  2    last reset source: 00 port, 01 external, 10 soft
//   rst_count    out  8    ext/soft reset events since reset, saturating
// ---------------------------------------------------------------------------
module reset_sequencer #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ext_rst_n,
  input  logic           soft_rst_req,
  output logic [NCH-1:0] resetn_out,
  output logic           rst_done,
  output logic [1:0]     rst_cause,
  output logic [7:0]     rst_count
);

  // The counter serves both the hold phase and the inter-stage gap, so it
  // is sized for whichever of the two is longer and can never wrap.
  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  localparam logic [1:0] CAUSE_PORT = 2'b00;
  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] prime_q;

  logic           ext_act;
  logic           ext_real;
  logic           req;
  logic [NCH-1:0] next_mask;
  logic           next_all;

  // The synchroniser is cleared by reset, so for the first SYNC_STAGES
  // cycles afterwards it reads as an asserted external reset. That still
  // holds the sequence off (it is what delays the first release), but it
  // is not a genuine external event, so prime_q marks when the chain holds
  // real pin samples and only then may the external source claim rst_cause.
  always_comb begin
    ext_act  = ~sync_q[SYNC_STAGES-1];
    ext_real = ext_act & prime_q[SYNC_STAGES-1];
    req      = ext_act | soft_rst_req;
  end

  // Channels release as a thermometer code from bit 0 upwards. Shifting a
  // one into the mask releases the next channel; once the mask would become
  // all ones the sequence is complete. From HOLD the mask is zero, so the
  // first release yields bit 0 alone, which is already complete when NCH=1.
  always_comb begin
    next_mask = (resetn_out << 1) | NCH'(1);
    next_all  = &next_mask;
  end

  // Single sequencer: synchroniser, hold/gap counting, channel release,
  // and bookkeeping of the reset cause and event count. Every output is
  // a register written here, so nothing downstream sees combinational
  // glitches from the request logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HOLD;
      cnt        <= '0;
      sync_q     <= '0;
      prime_q    <= '0;
      resetn_out <= '0;
      rst_done   <= 1'b0;
      rst_cause  <= CAUSE_PORT;
      rst_count  <= 8'd0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ext_rst_n};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};

      case (state)
        HOLD: begin
          if (req) begin
            // A request during hold only restarts the hold time; the
            // event is already being serviced, so it is not counted again.
            cnt <= '0;
            if (ext_real) begin
              rst_cause <= CAUSE_EXT;
            end else if (soft_rst_req) begin
              rst_cause <= CAUSE_SOFT;
            end
          end else if (cnt == HOLD_LAST) begin
            cnt        <= '0;
            resetn_out <= next_mask;
            if (next_all) begin
              state    <= RUN;
              rst_done <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RELEASE: begin
          if (req) begin
            state      <= HOLD;
            cnt        <= '0;
            resetn_out <= '0;
            rst_done   <= 1'b0;
            rst_cause  <= ext_act ? CAUSE_EXT : CAUSE_SOFT;
            if (rst_count != 8'hFF) begin
              rst_count <= rst_count + 8'd1;
            end
          end else if (cnt == GAP_LAST) begin
            cnt        <= '0;
            resetn_out <= next_mask;
            if (next_all) begin
              state    <= RUN;
              rst_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RUN: begin
          if (req) begin
            state      <= HOLD;
            cnt        <= '0;
            resetn_out <= '0;
            rst_done   <= 1'b0;
            rst_cause  <= ext_act ? CAUSE_EXT : CAUSE_SOFT;
            if (rst_count != 8'hFF) begin
              rst_count <= rst_count + 8'd1;
            end
          end
        end

        default: begin
          state      <= HOLD;
          cnt        <= '0;
          resetn_out <= '0;
          rst_done   <= 1'b0;
        end
      endcase
    end
  end

endmodule
